// File: rtl/multicycle_controller.sv
// +--------------------------------------------------------------------------+
// | Module      : multicycle_controller                                      |
// | Description : Moore FSM plus combinational ALU/immediate decode that     |
// |               sequences a multicycle RISC-V datapath (lw, sw, R-type,    |
// |               I-type ALU, jal, beq). Optional bne support is enabled by  |
// |               defining the macro MC_BNE_EN.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       instr_done,
  output logic [3:0] state
);

  // State encodings
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  // Opcodes
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       branch_taken;
  logic       op_supported;

  assign op_supported = (Op == OP_LW)    || (Op == OP_SW)    ||
                        (Op == OP_RTYPE) || (Op == OP_ITYPE) ||
                        (Op == OP_JAL)   || (Op == OP_BEQ);

  // Next-state selection; illegal codes recover to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; reset overrides any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    RegWrite  = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch condition; bne support is optional
  always_comb begin
    branch_taken = 1'b0;
`ifdef MC_BNE_EN
    if (funct3 == 3'b000) begin
      branch_taken = zero;
    end else if (funct3 == 3'b001) begin
      branch_taken = ~zero;
    end
`else
    if (funct3 == 3'b000) begin
      branch_taken = zero;
    end
`endif
  end

  assign PCWrite = pc_update | (branch & branch_taken);

  // ALU control decode; subtract only for R-type with funct7[5] set
  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      2'b00: ALUControl = ALU_ADD;
      2'b01: ALUControl = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (Op[5] & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

  // Immediate format selected from the opcode
  always_comb begin
    case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign instr_done = (state_q == S_MEMWB)    || (state_q == S_MEMWRITE) ||
                      (state_q == S_ALUWB)    || (state_q == S_BEQ)      ||
                      ((state_q == S_DECODE) && !op_supported);

  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_multicycle_controller                                   |
// | Description : Scoreboard bench for multicycle_controller. The driver     |
// |               pushes a hand-computed expected output vector for every    |
// |               cycle; a monitor pops and compares on the falling edge.    |
// |               Honours MC_BNE_EN for the bne expectation.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       instr_done;
  logic [3:0] state;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .Op         (Op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .instr_done (instr_done),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   step_no       = 0;
  string cur_tag      = "reset";

  // Layout: st[4] pcw adr mw irw rs[2] sa[2] sb[2] alu[3] imm[2] rw done
  function automatic logic [20:0] pack(input logic [3:0] st, input logic pcw,
      input logic adr, input logic mw, input logic irw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] alu,
      input logic [1:0] imm, input logic rw, input logic d);
    return {st, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, d};
  endfunction

  // Expect one cycle of outputs, then advance to the next cycle
  task automatic ex(input logic [3:0] st, input logic pcw, input logic adr,
      input logic mw, input logic irw, input logic [1:0] rs, input logic [1:0] sa,
      input logic [1:0] sb, input logic [2:0] alu, input logic [1:0] imm,
      input logic rw, input logic d);
    exp_t e;
    e.v   = pack(st, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, d);
    e.tag = $sformatf("%s_step%0d", cur_tag, step_no);
    q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input string tag, input logic [6:0] op,
      input logic [2:0] f3, input logic f75, input logic z);
    cur_tag  = tag;
    step_no  = 0;
    Op       = op;
    funct3   = f3;
    funct7_5 = f75;
    zero     = z;
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [20:0] act;
      e   = q.pop_front();
      act = pack(state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUControl, ImmSrc, RegWrite, instr_done);
      checks_total++;
      if (act === e.v) begin
        checks_passed++;
      end else begin
        $display("FAIL %s: got %06h expected %06h (st pcw adr mw irw rs sa sb alu imm rw done)",
                 e.tag, act, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] XX = 7'b1111111;

  logic bne_pcw;

  initial begin
`ifdef MC_BNE_EN
    bne_pcw = 1'b1;
`else
    bne_pcw = 1'b0;
`endif
    rst = 1'b1;
    set_in("reset", LW, 3'b000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // lw: 0,1,2,3,4 then FETCH
    set_in("lw", LW, 3'b010, 1'b0, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
    ex(2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
    ex(3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
    ex(4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1);

    // sub: R-type funct7_5=1
    set_in("sub", RT, 3'b000, 1'b1, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
    ex(6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0);
    ex(7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1);

    // add: R-type funct7_5=0
    set_in("add", RT, 3'b000, 1'b0, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
    ex(6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 0, 0);
    ex(7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1);

    // slt and or (R-type)
    set_in("slt", RT, 3'b010, 1'b0, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
    ex(6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00, 0, 0);
    ex(7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1);
    set_in("or", RT, 3'b110, 1'b0, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
    ex(6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00, 0, 0);
    ex(7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1);

    // addi with funct7_5=1 must still add; andi decodes to and
    set_in("addi", IT, 3'b000, 1'b1, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
    ex(8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
    ex(7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1);
    set_in("andi", IT, 3'b111, 1'b0, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
    ex(8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 2'b00, 0, 0);
    ex(7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1);

    // beq taken / not taken
    set_in("beq_t", BR, 3'b000, 1'b0, 1'b1);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0, 0);
    ex(10, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 1);
    set_in("beq_nt", BR, 3'b000, 1'b0, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0, 0);
    ex(10, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 1);

    // bne: taken only when the option is built in; zero=1 never taken
    set_in("bne_z0", BR, 3'b001, 1'b0, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0, 0);
    ex(10, bne_pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 1);
    set_in("bne_z1", BR, 3'b001, 1'b0, 1'b1);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0, 0);
    ex(10, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 1);

    // unsupported opcode retires from DECODE
    set_in("illop", XX, 3'b000, 1'b0, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 1);

    // sw with reset asserted in MEMWRITE
    set_in("sw_rst", SW, 3'b010, 1'b0, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01, 0, 0);
    ex(2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0);
    rst = 1'b1;
    ex(5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 1);
    rst = 1'b0;

    // jal right after the reset
    set_in("jal", JL, 3'b000, 1'b0, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b11, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b11, 0, 0);
    ex(9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0);
    ex(7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1, 1);

    // lw aborted by reset in MEMREAD: MEMWB must never happen
    set_in("lw_rst", LW, 3'b010, 1'b0, 1'b0);
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
    ex(2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
    rst = 1'b1;
    ex(3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
    rst = 1'b0;
    ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
    ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);

    // let the monitor drain the last expectation
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", q.size());
      checks_total++;
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none. All encodings are fixed by this document.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Op  in  7  instruction[6:0] from instruction register.
REQ-005 funct3  in  3  instruction[14:12].
REQ-006 funct7_5  in  1  instruction[30].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 PCWrite  out  1  PC register enable.
REQ-009 AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 MemWrite  out  1  data memory write enable.
REQ-011 IRWrite  out  1  instruction register enable.
REQ-012 ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
REQ-013 ALUSrcA  out  2  SrcA select: 00=PC, 01=OldPC, 10=RD1.
REQ-014 ALUSrcB  out  2  SrcB select: 00=RD2, 01=ImmExt, 10=constant 4.
REQ-015 ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 ImmSrc  out  2  immediate format.
REQ-017 RegWrite  out  1  register file write enable.
REQ-018 instr_done  out  1  one-cycle pulse in the final state of each instruction.
REQ-019 state  out  4  current FSM state, for debug.

Function
REQ-020 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Codes 11-15 are illegal and go to FETCH on the next edge.
REQ-021 Transitions:
- FETCH->DECODE.
- DECODE by Op: 0000011 or 0100011 ->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1101111->JAL; 1100011->BEQ; any other Op ->FETCH.
- MEMADR: lw->MEMREAD, otherwise ->MEMWRITE.
- MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH.
- EXECUTER, EXECUTEI, JAL ->ALUWB; ALUWB->FETCH.
- BEQ->FETCH.
REQ-022 Moore outputs per state; any signal not listed is 0:
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
REQ-023 PCWrite = PCUpdate | (Branch & branch_taken). This path is combinational on zero, within the same cycle.
REQ-024 ALU decode is combinational:
- ALUOp 00 -> add; ALUOp 01 -> sub.
- ALUOp 10 by funct3: 000 -> sub if (Op[5] & funct7_5), else add; 010 -> slt; 110 -> or; 111 -> and; other values -> add.
REQ-025 ImmSrc is combinational from Op: 0100011->01, 1100011->10, 1101111->11, all others 00.
REQ-026 Latency in cycles: lw 5; sw 4; R-type 4; I-type ALU 4; jal 4; beq 3; unsupported Op 2, with no register or memory write.
REQ-027 instr_done is 1 in MEMWB, MEMWRITE, ALUWB, BEQ, and in DECODE when Op is unsupported.
REQ-028 branch_taken = zero when funct3=000. Any other funct3 depends on REQ-033.

Reset
REQ-029 While rst=1 at a rising edge, state loads FETCH. rst takes priority over every transition, including mid-instruction.
REQ-030 During the cycle after reset, outputs reflect FETCH: IRWrite=1, PCWrite=1, all write enables except IRWrite/PCWrite are 0, instr_done=0.
REQ-031 Reset asserted in any state aborts the instruction. No RegWrite or MemWrite is asserted in the cycle following the reset edge.

Configuration
REQ-032 Macro MC_BNE_EN.
REQ-033 With MC_BNE_EN defined: in BEQ, funct3=001 gives branch_taken=~zero, and funct3=000 behaves as REQ-028.
REQ-034 Without MC_BNE_EN: in BEQ, any funct3 other than 000 gives branch_taken=0, so PCWrite=0 and the instruction retires as not-taken.

Verification
REQ-035 rst=1 for 2 cycles, then release -> state=0, IRWrite=1, PCWrite=1, MemWrite=0, RegWrite=0.
REQ-036 lw (Op=0000011) -> states 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; instr_done=1 once.
REQ-037 sub (Op=0110011, funct3=000, funct7_5=1) -> ALUControl=001 in EXECUTER; add with funct7_5=0 -> 000; addi with funct7_5=1 -> 000.
REQ-038 beq with zero=1 -> PCWrite=1 in state 10; with zero=0 -> PCWrite=0. With MC_BNE_EN, bne (funct3=001) with zero=0 -> PCWrite=1.
REQ-039 Op=1111111 -> states 0,1,0; instr_done=1 in DECODE; RegWrite and MemWrite stay 0 throughout.
REQ-040 rst asserted while in MEMWRITE -> next state 0 with MemWrite=0; the following jal completes 0,1,9,7,0 with PCWrite=1 in JAL.
